// File: rtl/systolic_os_array.sv
// Output-stationary systolic matrix-multiply engine computing Y = A * X.
// Each accepted beat supplies one column of A and one row of X. The engine
// skews both operands internally, accumulates in an N x N grid of MAC cells,
// and then drains Y one row per out_valid/out_ready handshake.
module systolic_os_array #(
    parameter int N  = 8,
    parameter int DW = 8,
    parameter int AW = 32,
    parameter int KW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    input  logic                 signed_mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*DW-1:0]      a_col,
    input  logic [N*DW-1:0]      x_row,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*AW-1:0]      out_row,
    output logic [$clog2(N)-1:0] out_row_idx,
    output logic                 out_last
);

    localparam int RW = $clog2(N);
    localparam int CW = $clog2(2 * N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            sgn_q, sgn_d;
    logic [KW-1:0]   beats_q, beats_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   row_q, row_d;
    logic [N*AW-1:0] out_row_q, out_row_d;

    logic            clr;       // start accepted: wipe accumulators and pipelines
    logic            run;       // operands move and accumulate only in LOAD/FLUSH
    logic            accept;    // operand beat handshake
    logic [RW-1:0]   row_sel;   // accumulator row loaded into out_row next
    logic [N*AW-1:0] row_pack;

    // Operands at the array edges (after skew) and at each PE's west/north port.
    logic [DW-1:0]   a_edge [N];
    logic [DW-1:0]   x_edge [N];
    logic [DW-1:0]   a_w    [N][N];
    logic [DW-1:0]   x_n    [N][N];

    // Operand hops between neighbouring PEs, and the accumulators.
    logic [DW-1:0]   a_fwd_q [N][N-1];
    logic [DW-1:0]   x_fwd_q [N-1][N];
    logic [AW-1:0]   acc_q   [N][N];
    logic [AW-1:0]   acc_d   [N][N];

    assign in_ready    = (state_q == S_LOAD);
    assign busy        = (state_q != S_IDLE);
    assign out_valid   = (state_q == S_DRAIN);
    assign out_last    = out_valid && (row_q == RW'(N - 1));
    assign out_row_idx = row_q;
    assign out_row     = out_row_q;

    assign accept = in_valid && in_ready;
    assign run    = (state_q == S_LOAD) || (state_q == S_FLUSH);

    // Pick the accumulator row that out_row will hold after the next load.
    always_comb begin
        row_sel = '0;
        if (state_q == S_DRAIN && row_q != RW'(N - 1)) begin
            row_sel = row_q + RW'(1);
        end
        for (int j = 0; j < N; j++) begin
            row_pack[j*AW +: AW] = acc_q[row_sel][j];
        end
    end

    // Next-state and datapath-control logic for the job sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        k_d       = k_q;
        sgn_d     = sgn_q;
        beats_d   = beats_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        out_row_d = out_row_q;
        clr       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    k_d     = k_len;
                    sgn_d   = signed_mode;
                    beats_d = '0;
                    cnt_d   = CW'(2 * N - 2);
                    state_d = (k_len != '0) ? S_LOAD : S_FLUSH;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    beats_d = beats_q + KW'(1);
                    if (beats_q + KW'(1) == k_q) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // 2N-1 cycles lets the last beat cross the full skewed wavefront.
                if (cnt_q == '0) begin
                    state_d   = S_DRAIN;
                    row_d     = '0;
                    out_row_d = row_pack;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (row_q == RW'(N - 1)) begin
                        state_d = S_IDLE;
                        row_d   = '0;
                    end else begin
                        row_d     = row_q + RW'(1);
                        out_row_d = row_pack;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state register; reset aborts any job in flight.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            sgn_q     <= 1'b0;
            beats_q   <= '0;
            cnt_q     <= '0;
            row_q     <= '0;
            out_row_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            sgn_q     <= sgn_d;
            beats_q   <= beats_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            out_row_q <= out_row_d;
        end
    end

    // Input skew: lane i of A and lane j of X are delayed i and j cycles.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        logic [DW-1:0] a_lane;
        logic [DW-1:0] x_lane;

        // Cycles without an accepted beat inject zeros, which leave sums intact.
        assign a_lane = accept ? a_col[gi*DW +: DW] : '0;
        assign x_lane = accept ? x_row[gi*DW +: DW] : '0;

        if (gi == 0) begin : g_direct
            assign a_edge[gi] = a_lane;
            assign x_edge[gi] = x_lane;
        end else begin : g_delay
            logic [DW-1:0] a_sr_q [gi];
            logic [DW-1:0] x_sr_q [gi];

            // Shift register of depth gi for this lane.
            always_ff @(posedge clk) begin
                // NOTE: the skew chains are cleared explicitly; stale operands
                // left over from an aborted job would otherwise leak into the next.
                if (rst || clr) begin
                    for (int k = 0; k < gi; k++) begin
                        a_sr_q[k] <= '0;
                        x_sr_q[k] <= '0;
                    end
                end else if (run) begin
                    a_sr_q[0] <= a_lane;
                    x_sr_q[0] <= x_lane;
                    for (int k = 1; k < gi; k++) begin
                        a_sr_q[k] <= a_sr_q[k-1];
                        x_sr_q[k] <= x_sr_q[k-1];
                    end
                end
            end

            assign a_edge[gi] = a_sr_q[gi-1];
            assign x_edge[gi] = x_sr_q[gi-1];
        end
    end

    // PE grid wiring and multiply-accumulate.
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic [AW-1:0] a_ext;
            logic [AW-1:0] x_ext;

            if (gj == 0) begin : g_w_edge
                assign a_w[gi][gj] = a_edge[gi];
            end else begin : g_w_hop
                assign a_w[gi][gj] = a_fwd_q[gi][gj-1];
            end

            if (gi == 0) begin : g_n_edge
                assign x_n[gi][gj] = x_edge[gj];
            end else begin : g_n_hop
                assign x_n[gi][gj] = x_fwd_q[gi-1][gj];
            end

            // Extending both operands to AW makes the AW-bit product correct
            // modulo 2^AW for signed and unsigned modes alike.
            assign a_ext = {{(AW-DW){sgn_q & a_w[gi][gj][DW-1]}}, a_w[gi][gj]};
            assign x_ext = {{(AW-DW){sgn_q & x_n[gi][gj][DW-1]}}, x_n[gi][gj]};
            assign acc_d[gi][gj] = acc_q[gi][gj] + a_ext * x_ext;
        end
    end

    // Grid registers: operand hops and accumulators, frozen outside LOAD/FLUSH.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc_q[i][j] <= '0;
                end
                for (int j = 0; j < N - 1; j++) begin
                    a_fwd_q[i][j] <= '0;
                end
            end
            for (int i = 0; i < N - 1; i++) begin
                for (int j = 0; j < N; j++) begin
                    x_fwd_q[i][j] <= '0;
                end
            end
        end else if (run) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc_q[i][j] <= acc_d[i][j];
                end
                for (int j = 0; j < N - 1; j++) begin
                    a_fwd_q[i][j] <= a_w[i][j];
                end
            end
            for (int i = 0; i < N - 1; i++) begin
                for (int j = 0; j < N; j++) begin
                    x_fwd_q[i][j] <= x_n[i][j];
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_os_array.sv
// Directed self-checking bench for systolic_os_array at N=4.
module tb_systolic_os_array;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int KW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            signed_mode;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] a_col;
    logic [N*DW-1:0] x_row;
    logic            busy;
    logic            out_valid;
    logic            out_ready;
    logic [N*AW-1:0] out_row;
    logic [1:0]      out_row_idx;
    logic            out_last;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [DW-1:0] ma [N][N];   // ma[i][k] = A[i][k]
    logic [DW-1:0] mx [N][N];   // mx[k][j] = X[k][j]
    logic [AW-1:0] ey [N][N];   // expected Y[r][j]

    systolic_os_array #(.N(N), .DW(DW), .AW(AW), .KW(KW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .k_len       (k_len),
        .signed_mode (signed_mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_col       (a_col),
        .x_row       (x_row),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_job(input int k, input bit sgn);
        start       = 1'b1;
        k_len       = KW'(k);
        signed_mode = sgn;
        tick();
        start = 1'b0;
    endtask

    // Present nb beats; optional 2-cycle bubble after the first beat.
    task automatic feed(input int nb, input bit bubble, input bit expect_done);
        for (int b = 0; b < nb; b++) begin
            if (bubble && b == 1) begin
                for (int c = 0; c < 2; c++) begin
                    in_valid = 1'b0;
                    check("in_ready_bubble", 32'(in_ready), 32'd1);
                    tick();
                end
            end
            for (int i = 0; i < N; i++) begin
                a_col[i*DW +: DW] = ma[i][b];
                x_row[i*DW +: DW] = mx[b][i];
            end
            in_valid = 1'b1;
            check($sformatf("in_ready_beat%0d", b), 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        a_col    = '0;
        x_row    = '0;
        if (expect_done) check("in_ready_after_load", 32'(in_ready), 32'd0);
    endtask

    task automatic wait_valid(input bit chk_ready);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            if (chk_ready) check("flush_in_ready", 32'(in_ready), 32'd0);
            tick();
            n++;
        end
        check("out_valid_seen", 32'(out_valid), 32'd1);
    endtask

    // Drain all rows; toggle gives out_ready pattern 1,0,0,1,0,0,...
    task automatic drain(input bit toggle);
        int r;
        int c;
        r = 0;
        c = 0;
        while (r < N && c < 60) begin
            out_ready = toggle ? (c % 3 == 0) : 1'b1;
            check($sformatf("drain_valid_c%0d", c), 32'(out_valid), 32'd1);
            check($sformatf("row_idx_c%0d", c), 32'(out_row_idx), 32'(r));
            check($sformatf("out_last_c%0d", c), 32'(out_last), 32'(r == N - 1));
            for (int j = 0; j < N; j++) begin
                check($sformatf("y_r%0d_j%0d_c%0d", r, j, c), out_row[j*AW +: AW], ey[r][j]);
            end
            if (out_ready) r++;
            tick();
            c++;
        end
        out_ready = 1'b0;
        check("handshakes", 32'(r), 32'(N));
        check("busy_after_drain", 32'(busy), 32'd0);
        check("valid_after_drain", 32'(out_valid), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_row_idx"}, 32'(out_row_idx), 32'd0);
        for (int j = 0; j < N; j++) begin
            check($sformatf("%s_out_row%0d", tag, j), out_row[j*AW +: AW], 32'd0);
        end
    endtask

    initial begin
        int t0;
        rst         = 1'b1;
        start       = 1'b0;
        k_len       = '0;
        signed_mode = 1'b0;
        in_valid    = 1'b0;
        a_col       = '0;
        x_row       = '0;
        out_ready   = 1'b0;

        // Reset state.
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Job 1: unsigned, K=4, A = identity, X[k][j] = 4k+j+1.
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                ma[i][k] = (i == k) ? 8'd1 : 8'd0;
                mx[i][k] = DW'(4 * i + k + 1);
                ey[i][k] = AW'(4 * i + k + 1);
            end
        end
        t0 = cyc;
        start_job(4, 1'b0);
        check("job1_busy", 32'(busy), 32'd1);
        feed(4, 1'b0, 1'b1);
        wait_valid(1'b1);
        check("job1_latency", 32'(cyc - t0), 32'd12);
        drain(1'b0);

        // Job 2a: signed, K=2, A = -1, X = 2 -> every Y = -4.
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                ma[i][k] = 8'hFF;
                mx[i][k] = 8'h02;
                ey[i][k] = 32'hFFFF_FFFC;
            end
        end
        start_job(2, 1'b1);
        feed(2, 1'b0, 1'b1);
        wait_valid(1'b0);
        drain(1'b0);

        // Job 2b: same operands unsigned -> every Y = 2*255*2 = 1020.
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                ey[i][k] = 32'd1020;
            end
        end
        start_job(2, 1'b0);
        feed(2, 1'b0, 1'b1);
        wait_valid(1'b0);
        drain(1'b0);

        // Job 3: K=3 with a 2-cycle bubble; A[i][k]=i+1, X[k][j]=(k+1)(j+1)
        // so Y[i][j] = 6(i+1)(j+1). Drained under 1,0,0 backpressure.
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                ma[i][k] = DW'(i + 1);
                mx[i][k] = DW'((i + 1) * (k + 1));
                ey[i][k] = AW'(6 * (i + 1) * (k + 1));
            end
        end
        start_job(3, 1'b0);
        feed(3, 1'b1, 1'b1);
        wait_valid(1'b0);
        drain(1'b1);

        // Job 4: k_len=0 -> straight to a 7-cycle FLUSH, then zero rows.
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                ey[i][k] = '0;
            end
        end
        t0 = cyc;
        start_job(0, 1'b0);
        check("k0_busy", 32'(busy), 32'd1);
        wait_valid(1'b1);
        check("k0_latency", 32'(cyc - t0), 32'd8);
        // A start during DRAIN must not disturb the job.
        start_job(5, 1'b0);
        check("ign_start_busy", 32'(busy), 32'd1);
        check("ign_start_in_ready", 32'(in_ready), 32'd0);
        check("ign_start_valid", 32'(out_valid), 32'd1);
        check("ign_start_idx", 32'(out_row_idx), 32'd0);
        drain(1'b0);

        // Job 5: abort mid-LOAD with reset, then K=1 with all-ones operands.
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                ma[i][k] = 8'd3;
                mx[i][k] = 8'd5;
            end
        end
        start_job(4, 1'b0);
        feed(2, 1'b0, 1'b0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("abort");
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                ma[i][k] = 8'd1;
                mx[i][k] = 8'd1;
                ey[i][k] = 32'd1;
            end
        end
        start_job(1, 1'b0);
        feed(1, 1'b0, 1'b1);
        wait_valid(1'b0);
        drain(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_os_array.md
Name: systolic_os_array

Overview:
- Parametrised output-stationary systolic matrix-multiply engine computing Y = A·X.
  - A is N×K, X is K×N, K is runtime-selectable.
  - Each cycle it accepts one column of A and one row of X, and skews them internally.
- It accumulates in an N×N grid of MAC cells, then drains Y one row per handshake.
- It is the controlled, generalised successor to the fixed 8×8 array. It adds:
  - input skewing and an operand handshake
  - a signed/unsigned mode
  - accumulator clear on start
  - a flush/drain sequence with result backpressure

Parameters:
- N, 8, array dimension (rows = columns of PEs), 2..16
- DW, 8, operand width in bits
- AW, 32, accumulator width in bits; must be ≥ 2*DW
- KW, 8, width of k_len; max K = 2^KW-1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; begins a job (accepted only when busy=0)
- k_len  in  KW  inner dimension K, sampled with start
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- in_valid  in  1  operand beat valid
- in_ready  out  1  engine accepts operand beat
- a_col  in  N*DW  A[0..N-1][k]; lane i at bits [i*DW +: DW]
- x_row  in  N*DW  X[k][0..N-1]; lane j at bits [j*DW +: DW]
- busy  out  1  job in progress (any state other than IDLE)
- out_valid  out  1  out_row holds valid Y row
- out_ready  in  1  consumer accepts Y row
- out_row  out  N*AW  Y[r][0..N-1]; lane j at bits [j*AW +: AW]
- out_row_idx  out  $clog2(N)  row index r of out_row
- out_last  out  1  out_row is row N-1

Behaviour:
- Reset: synchronous on clk when rst=1; rst overrides all other inputs.
  - After reset: state=IDLE; in_ready, busy, out_valid, out_last = 0; out_row_idx=0; out_row=0.
  - All accumulators, skew registers and PE pipeline registers = 0.
  - Reset mid-job aborts the job; no partial result is emitted.
- States:
  - IDLE:
    - start=1 → latch k_len and signed_mode; clear all accumulators to 0.
    - If k_len≠0 → LOAD, else → FLUSH.
  - LOAD: in_ready=1.
    - A beat is accepted when in_valid & in_ready.
    - After the K-th accepted beat → FLUSH.
  - FLUSH: in_ready=0. Stays for exactly 2N-1 cycles, counted by a down-counter, then → DRAIN.
  - DRAIN: out_valid=1 with row r (r starts at 0).
    - On out_valid & out_ready: r increments.
    - On the handshake of row N-1 (out_last=1) → IDLE.
- start while busy=1 is ignored, with no effect on the current job.
- Skewing: lane i of a_col is delayed i cycles before entering PE row i. Lane j of x_row is delayed j cycles before entering PE column j. Skew registers are all-zero after reset and clear.
- Bubbles: any cycle in LOAD or FLUSH without an accepted beat injects zeros at both array edges.
  - Zero products do not disturb the accumulators.
  - The array never stalls; only accepted beats count toward K.
- PE (i,j), each cycle:
  - Register the west/north operands and forward them east/south (1-cycle hop).
  - acc += ext(a)*ext(x). ext is sign- or zero-extension per the latched signed_mode.
  - Sum is truncated modulo 2^AW; no saturation.
- Timing: the beat accepted at cycle t contributes to PE(i,j) at cycle t+i+j+1. The last beat is fully accumulated in all PEs by the end of FLUSH.
- out_row:
  - Registered and stable while out_valid=1 and out_ready=0.
  - Accumulators are frozen during DRAIN.
- Simultaneous events:
  - A final beat accepted in the same cycle as LOAD→FLUSH counts as beat K.
  - out_ready held high drains one row per cycle; the first row is presented the cycle after FLUSH ends.
- Total latency, start to first out_valid with no bubbles and no backpressure: 1 + K + (2N-1) cycles.
- k_len=0: result is all zeros, drained normally.

Test Plan:
- N=4, unsigned, K=4, A=identity, X[k][j]=4k+j+1 → rows Y[r]=X[r] (row 0 = 1,2,3,4). out_last on row 3. First out_valid exactly 1+4+7=12 cycles after start.
- N=4, signed, K=2, A all 0xFF (-1), X all 0x02 → every Y = -4 (0xFFFFFFFC). Same data unsigned → every Y = 2*255*2 = 1020.
- N=4, K=3, in_valid deasserted for 2 cycles between beats 1 and 2 → results identical to the bubble-free run; in_ready stays 1 until beat 3 is accepted.
- DRAIN with out_ready toggling 1,0,0,1,... → each row held stable while stalled; out_row_idx sequence 0,1,2,3; exactly 4 handshakes; then busy=0.
- k_len=0 start → no in_ready, FLUSH of 2N-1 cycles, 4 rows of zeros. A second start issued during DRAIN is ignored.
- rst asserted mid-LOAD after 2 beats, then a new job with K=1, A=X=all 1 → every Y=1 (no residue from the aborted job).
